// File: rtl/wrr_arbiter.sv
// N-requester weighted round-robin arbiter with registered one-hot grant,
// per-requester burst weights and an encoded grant index.
module wrr_arbiter #(
   parameter int N     = 4,
   parameter int CNT_W = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_an,
   input  logic [N-1:0]         req,
   input  logic [N*CNT_W-1:0]   weight,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [IDX_W-1:0]     grant_id
);

   logic [N-1:0]     grant_q, grant_d;
   logic             grant_valid_q, grant_valid_d;
   logic [IDX_W-1:0] grant_id_q, grant_id_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [CNT_W-1:0] credit_q, credit_d;

   logic [CNT_W-1:0] weight_arr [N];
   logic [IDX_W-1:0] cand;
   logic [IDX_W-1:0] winner;
   logic             found;
   logic             owner_req;
   logic             hold;
   logic [CNT_W-1:0] reload;

   for (genvar g = 0; g < N; g++) begin : g_weight
      assign weight_arr[g] = weight[g*CNT_W +: CNT_W];
   end

   // Circular priority search starting just past the last owner.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      found  = 1'b0;
      winner = last_q;
      cand   = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IDX_W'((int'(last_q) + i) % N);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign owner_req = |(grant_q & req);
   assign hold      = owner_req && (credit_q > CNT_W'(1));
   assign reload    = (weight_arr[winner] == '0) ? CNT_W'(1) : weight_arr[winner];

   always_comb begin
      grant_d       = grant_q;
      grant_valid_d = grant_valid_q;
      grant_id_d    = grant_id_q;
      last_d        = last_q;
      credit_d      = credit_q;
      if (hold) begin
         credit_d = credit_q - CNT_W'(1);
      end else if (found) begin
         grant_d         = '0;
         grant_d[winner] = 1'b1;
         grant_valid_d   = 1'b1;
         grant_id_d      = winner;
         last_d          = winner;
         credit_d        = reload;
      end else begin
         // Idle: pointer and index are kept so fairness resumes where it left off.
         grant_d       = '0;
         grant_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_id_q    <= '0;
         last_q        <= IDX_W'(N - 1);
         credit_q      <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update together.
         grant_q       <= grant_d;
         grant_valid_q <= grant_valid_d;
         grant_id_q    <= grant_id_d;
         last_q        <= last_d;
         credit_q      <= credit_d;
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Self-checking bench for wrr_arbiter: directed scenarios plus random traffic
// compared against a burst-counting reference model.
module tb_wrr_arbiter;

   localparam int N     = 4;
   localparam int CNT_W = 4;
   localparam int IDX_W = $clog2(N);

   logic               clk = 1'b0;
   logic               rst_an = 1'b1;
   logic [N-1:0]       req = '0;
   logic [N*CNT_W-1:0] weight = '0;
   logic [N-1:0]       grant;
   logic               grant_valid;
   logic [IDX_W-1:0]   grant_id;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the resource, how many grant cycles it has had,
   // and how long its burst may be.
   int m_last;
   int m_owner;
   int m_used;
   int m_burst;
   int m_id;

   logic [N-1:0] req_edge;
   logic [N-1:0] prev_grant;

   wrr_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_an      (rst_an),
      .req         (req),
      .weight      (weight),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int weight_of(input logic [N*CNT_W-1:0] w, input int p);
      int v;
      v = int'(w[p*CNT_W +: CNT_W]);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_reset();
      m_last  = N - 1;
      m_owner = -1;
      m_used  = 0;
      m_burst = 0;
      m_id    = 0;
   endtask

   task automatic model_edge(input logic [N-1:0] r, input logic [N*CNT_W-1:0] w);
      int win;
      if (m_owner >= 0 && r[m_owner] && m_used < m_burst) begin
         m_used++;
      end else begin
         win = -1;
         for (int k = 1; k <= N; k++) begin
            if (win < 0 && r[(m_last + k) % N]) win = (m_last + k) % N;
         end
         m_owner = win;
         if (win >= 0) begin
            m_last  = win;
            m_id    = win;
            m_used  = 1;
            m_burst = weight_of(w, win);
         end
      end
   endtask

   function automatic logic [N-1:0] m_grant();
      return (m_owner >= 0) ? (N'(1) << m_owner) : '0;
   endfunction

   // One clock: model follows the inputs present at the edge, outputs checked 1ns later.
   task automatic step();
      logic [N*CNT_W-1:0] w_edge;
      req_edge   = req;
      w_edge     = weight;
      prev_grant = grant;
      @(posedge clk);
      model_edge(req_edge, w_edge);
      #1;
      check("grant", 32'(grant), 32'(m_grant()));
      check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      check("grant_id", 32'(grant_id), 32'(m_id));
      check("onehot0", 32'($onehot0(grant)), 32'd1);
      check("valid_or", 32'(grant_valid), 32'(|grant));
      if (grant_valid) check("id_bit", 32'(grant[grant_id]), 32'd1);
      for (int i = 0; i < N; i++) begin
         if (grant[i] && !prev_grant[i]) check("rise_req", 32'(req_edge[i]), 32'd1);
      end
   endtask

   // Asynchronous reset: outputs must clear before any clock edge arrives.
   task automatic do_reset();
      #2;
      rst_an = 1'b0;
      #1;
      model_reset();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_valid", 32'(grant_valid), 32'd0);
      check("rst_id", 32'(grant_id), 32'd0);
      @(posedge clk);
      #2;
      check("rst_hold_grant", 32'(grant), 32'd0);
      rst_an = 1'b1;
   endtask

   initial begin
      int rr_exp [8];
      int wt_exp [10];
      rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
      wt_exp = '{0, 0, 0, 1, 2, 2, 3, 0, 0, 0};
      model_reset();

      // Reset mid-burst, then first grant goes to requester 0.
      do_reset();
      weight = 16'h2222;
      req    = 4'b1111;
      step();
      step();
      do_reset();
      step();
      check("first_after_reset", 32'(grant), 32'h1);

      // Plain round robin with unit weights.
      do_reset();
      weight = 16'h1111;
      req    = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         step();
         check("rr_seq", 32'(grant), 32'(4'b0001 << rr_exp[i]));
      end

      // Weighted bursts w0=3 w1=1 w2=2 w3=1.
      do_reset();
      weight = 16'h1213;
      req    = 4'b1111;
      for (int i = 0; i < 10; i++) begin
         step();
         check("wrr_seq", 32'(grant_id), 32'(wt_exp[i]));
      end

      // Early release of requester 0 in the middle of a 4-cycle burst.
      do_reset();
      weight = 16'h0024;
      req    = 4'b0011;
      step();
      step();
      check("early_hold", 32'(grant), 32'h1);
      req = 4'b0010;
      step();
      check("early_switch", 32'(grant), 32'h2);
      req = 4'b0011;
      step();
      check("early_w1", 32'(grant), 32'h2);
      step();
      check("early_back0", 32'(grant), 32'h1);

      // Sole requester with zero weight, then two zero-weight requesters alternate.
      do_reset();
      weight = 16'h0000;
      req    = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         step();
         check("sole_grant", 32'(grant), 32'h4);
      end
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         step();
         check("alt_grant", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h4);
      end

      // Idle keeps grant_id and the pointer; the next grant resumes after requester 2.
      do_reset();
      weight = 16'h1111;
      req    = 4'b0100;
      step();
      req = 4'b0000;
      for (int i = 0; i < 3; i++) begin
         step();
         check("idle_grant", 32'(grant), 32'h0);
         check("idle_id", 32'(grant_id), 32'd2);
      end
      req = 4'b1111;
      step();
      check("idle_resume", 32'(grant), 32'h8);

      // Random traffic with occasional weight changes and one asynchronous reset.
      do_reset();
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         if (c % 37 == 0) weight = (N*CNT_W)'($urandom);
         if (c == 200) do_reset();
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wrr_arbiter.md
Name: wrr_arbiter

Overview:
- N-requester weighted round-robin arbiter. Parametrised successor to the team's 2-port round-robin arbiter.
- Adds configurable requester count, per-requester burst weight (consecutive grant cycles) and an encoded grant index.
- Sits between N bus/request masters and a single shared resource. Grant outputs are registered.

Parameters:
- N, 4, number of requesters (N >= 2).
- CNT_W, 4, width of each per-requester weight field and of the internal credit counter.
- IDX_W, $clog2(N), width of the grant_id output (derived; do not override).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_an  input  1  asynchronous, active-low reset.
- req  input  N  request vector, bit i = requester i.
- weight  input  N*CNT_W  per-requester weight; field i = weight[i*CNT_W +: CNT_W]. Quasi-static config; value 0 is treated as 1.
- grant  output  N  one-hot registered grant, all-zero when idle.
- grant_valid  output  1  registered, equal to |grant.
- grant_id  output  IDX_W  registered binary index of the granted requester; holds its last value when idle.

Behaviour:
- Reset (rst_an low, asynchronous, any time including mid-burst):
  - grant=0, grant_valid=0, grant_id=0, credit=0.
  - Last-owner pointer=N-1, so requester 0 has top priority after reset.
  - Outputs clear immediately, without waiting for a clock edge.
- Internal state: last-owner pointer (IDX_W), credit counter (CNT_W), registered grant.
- Latency: req sampled at edge k drives grant after edge k (1-cycle latency). Outputs never depend combinationally on req.
- Each rising edge, exactly one of the following applies:
  - HOLD: grant[owner]=1, req[owner]=1 and credit>1 -> grant unchanged, credit decrements by 1.
  - ARBITRATE: all other cases (idle, owner dropped req, or credit==1).
    - Search req circularly starting at (last+1) mod N. First set bit wins.
    - grant <= one-hot(winner), grant_id <= winner, last <= winner.
    - credit <= max(weight[winner],1). Weight is sampled only here; changes mid-burst take effect at the next grant.
  - NO REQUEST: no req bit set -> grant=0, grant_valid=0. last and grant_id retain their values; credit is don't-care (reloaded on the next grant).
- Burst length: an owner keeping req high receives exactly max(weight,1) consecutive grant cycles before re-arbitration.
- Owner drop: owner deasserts req during cycle t -> grant moves to the next requester, or goes to 0, at the edge ending cycle t. One grant cycle overlaps the deasserted req; this is accepted.
- Sole requester: credit exhausted and no other req -> the same requester is re-granted with credit reloaded. No idle bubble.
- Wrap-around: the circular search wraps from N-1 to 0. The pointer always advances past the last owner, so a continuously requesting port waits at most (N-1)*max_weight cycles.
- Simultaneous owner drop and new requests: resolved by the ARBITRATE rule in the same edge.
- Invariants, checked by assertions in the bench:
  - grant is one-hot or zero.
  - grant_valid == |grant.
  - When grant_valid=1, grant[grant_id]=1.
  - grant bit i rises only if req[i] was 1 at the preceding edge.

Test Plan:
- Reset: apply req=4'b1111, then pulse rst_an low mid-burst between clock edges -> grant=0, grant_valid=0, grant_id=0 immediately. After release with req=4'b1111, the first grant is 4'b0001.
- Plain round robin: all weights=1, req=4'b1111 held -> grant sequence 0001,0010,0100,1000,0001,... with one requester per cycle and no gaps.
- Weighted: weights {w0=3,w1=1,w2=2,w3=1}, req=4'b1111 held -> grant_id sequence 0,0,0,1,2,2,3,0,0,0,...
- Early release: w0=4, req=4'b0011. req0 drops after grant0 has been high 2 cycles -> grant switches to 4'b0010 at the edge after the drop. grant1 lasts w1 cycles; grant then returns to 0 only if req0 is re-raised.
- Sole requester and zero weight: req=4'b0100, w2=0 -> grant=4'b0100 every cycle with no bubble. Then req=4'b0101 with w0=0 -> grant alternates 0001/0100 each cycle.
- Idle hold: after a grant to 2, req=0 for 3 cycles -> grant=0, grant_valid=0, grant_id stays 2. Then req=4'b1111 -> next grant is 4'b1000.
